// File: rtl/h80cpu_uart_io_pkg.sv
// h80cpu I/O bus types plus UART register map and STATUS bit positions.
package h80cpu_uart_io_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    typedef logic [BUS_ADDR_W-1:0] bus_addr_t;
    typedef logic [BUS_DATA_W-1:0] bus_data_t;

    typedef enum logic {
        bus_cmd_read_b  = 1'b0,
        bus_cmd_write_b = 1'b1
    } bus_cmd_t;

    // Register offsets relative to the peripheral base address
    localparam bus_addr_t UART_REG_DATA   = 16'd0;
    localparam bus_addr_t UART_REG_STATUS = 16'd1;
    localparam bus_addr_t UART_REG_DIV    = 16'd2;
    localparam bus_addr_t UART_REG_CTRL   = 16'd3;

    // STATUS register bit positions
    localparam int UART_ST_TX_FULL   = 0;
    localparam int UART_ST_TX_EMPTY  = 1;
    localparam int UART_ST_RX_VALID  = 2;
    localparam int UART_ST_RX_OVRN   = 3;
    localparam int UART_ST_RX_FRMERR = 4;
    localparam int UART_ST_TX_IDLE   = 5;

    typedef enum logic [1:0] {
        TXS_IDLE  = 2'd0,
        TXS_START = 2'd1,
        TXS_DATA  = 2'd2,
        TXS_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RXS_IDLE  = 2'd0,
        RXS_START = 2'd1,
        RXS_DATA  = 2'd2,
        RXS_STOP  = 2'd3
    } rx_state_t;

    // A divisor below 2 cannot produce a half-bit sample point, so clamp it
    function automatic logic [15:0] uart_div_sanitize(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/h80cpu_io_fifo.sv
// Synchronous first-word-fall-through FIFO; push into a full FIFO is taken
// only when a pop happens in the same cycle.
module h80cpu_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop & (r_count != '0);
    assign w_do_push = push & ((r_count != FULL_CNT) | w_do_pop);

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

    // Storage write; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/h80cpu_uart_io.sv
// h80cpu_uart_io: memory-mapped UART with TX/RX FIFOs, run/done bus handshake,
// programmable bit divisor and a registered level interrupt.
//
//   state      | meaning
//   TXS_IDLE   | line high, waiting for a byte in the TX FIFO
//   TXS_START  | driving the start bit (0) for DIV clocks
//   TXS_DATA   | shifting 8 data bits LSB first
//   TXS_STOP   | driving the stop bit (1); may chain straight into the next START
//   RXS_IDLE   | waiting for a 1->0 edge on the synchronised input
//   RXS_START  | half-bit wait, then confirm the start bit is still low
//   RXS_DATA   | sampling 8 data bits at bit centres
//   RXS_STOP   | sampling the stop bit; low means framing error
module h80cpu_uart_io
    import h80cpu_uart_io_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16,
    parameter bus_addr_t   BASE_ADDR = 16'h0000
) (
    input  logic      clk,
    input  logic      reset,
    input  bus_addr_t addr,
    input  bus_cmd_t  cmd,
    input  logic      run,
    input  bus_data_t wr_data,
    output bus_data_t rd_data,
    output logic      done,
    input  logic      uart_rxp,
    output logic      uart_txp,
    output logic      irq
);
    localparam int TXC_W = $clog2(TX_DEPTH) + 1;
    localparam int RXC_W = $clog2(RX_DEPTH) + 1;
    localparam logic [15:0] DIV_RESET = uart_div_sanitize(16'(CLK_FREQ / BAUD));

    logic        r_done;
    bus_data_t   r_rd_data;
    logic [15:0] r_div;
    logic [1:0]  r_ctrl;
    logic        r_overrun;
    logic        r_frame_err;
    logic        r_irq;

    logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]       w_tx_rdata;
    logic [TXC_W-1:0] w_tx_count;
    logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]       w_rx_rdata;
    logic [RXC_W-1:0] w_rx_count;
    logic             w_unused_rx_count;

    bus_addr_t w_off;
    logic      w_req, w_wr, w_stall, w_accept, w_st_read;
    logic      w_sel_data, w_sel_status, w_sel_div, w_sel_ctrl;
    bus_data_t w_status, w_rd_val;
    logic      w_ov_set, w_fe_set, w_tx_idle;

    tx_state_t   r_tx_state, w_tx_state_nx;
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [7:0]  r_tx_shift;
    logic [2:0]  r_tx_bit;
    logic        r_txp;
    logic        w_tx_start, w_tx_bit_end;

    rx_state_t   r_rx_state, w_rx_state_nx;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [15:0] r_rx_cnt, r_rx_div;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_rx_bit;
    logic        w_rx_start, w_rx_bit_end, w_rx_stop_end;

    h80cpu_io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(w_tx_push), .pop(w_tx_pop), .wdata(wr_data[7:0]),
        .rdata(w_tx_rdata), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    h80cpu_io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(w_rx_push), .pop(w_rx_pop), .wdata(r_rx_shift),
        .rdata(w_rx_rdata), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    assign w_unused_rx_count = ^w_rx_count;

    // ---------------- bus decode ----------------
    assign w_off        = addr - BASE_ADDR;
    assign w_req        = run ^ r_done;
    assign w_wr         = (cmd == bus_cmd_write_b);
    assign w_sel_data   = (w_off == UART_REG_DATA);
    assign w_sel_status = (w_off == UART_REG_STATUS);
    assign w_sel_div    = (w_off == UART_REG_DIV);
    assign w_sel_ctrl   = (w_off == UART_REG_CTRL);
    // Stall on count rather than full so a same-cycle pop does not release early
    assign w_stall      = w_req & w_wr & w_sel_data & (w_tx_count == TXC_W'(TX_DEPTH));
    assign w_accept     = w_req & ~w_stall;
    assign w_tx_push    = w_accept & w_wr & w_sel_data;
    assign w_rx_pop     = w_accept & ~w_wr & w_sel_data & ~w_rx_empty;
    assign w_st_read    = w_accept & ~w_wr & w_sel_status;
    assign w_tx_idle    = w_tx_empty & (r_tx_state == TXS_IDLE);

    // Assemble STATUS from live FIFO/FSM state and sticky flags
    always_comb begin
        w_status = '0;
        w_status[UART_ST_TX_FULL]   = w_tx_full;
        w_status[UART_ST_TX_EMPTY]  = w_tx_empty;
        w_status[UART_ST_RX_VALID]  = ~w_rx_empty;
        w_status[UART_ST_RX_OVRN]   = r_overrun;
        w_status[UART_ST_RX_FRMERR] = r_frame_err;
        w_status[UART_ST_TX_IDLE]   = w_tx_idle;
    end

    // Read data mux; unmapped offsets and an empty RX FIFO read as zero
    always_comb begin
        w_rd_val = '0;
        if (w_sel_data && !w_rx_empty) w_rd_val = bus_data_t'(w_rx_rdata);
        else if (w_sel_status)         w_rd_val = w_status;
        else if (w_sel_div)            w_rd_val = bus_data_t'(r_div);
        else if (w_sel_ctrl)           w_rd_val = bus_data_t'(r_ctrl);
    end

    // Bus completion, read data capture and writable registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_rd_data <= '0;
            r_div     <= DIV_RESET;
            r_ctrl    <= '0;
        end else if (w_accept) begin
            r_done <= ~r_done;
            if (w_wr) begin
                if (w_sel_div)  r_div  <= uart_div_sanitize(wr_data[15:0]);
                if (w_sel_ctrl) r_ctrl <= wr_data[1:0];
            end else begin
                r_rd_data <= w_rd_val;
            end
        end
    end

    // Sticky error flags (set beats a same-cycle STATUS read) and registered irq
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_overrun   <= w_ov_set | (r_overrun & ~w_st_read);
            r_frame_err <= w_fe_set | (r_frame_err & ~w_st_read);
            r_irq       <= (~w_rx_empty & r_ctrl[0]) | (w_tx_empty & r_ctrl[1]);
        end
    end

    // ---------------- transmitter ----------------
    // TX state register
    always_ff @(posedge clk) begin
        if (reset) r_tx_state <= TXS_IDLE;
        else       r_tx_state <= w_tx_state_nx;
    end

    // TX next-state; a stop bit ending with data queued goes straight to START
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_pop      = 1'b0;
        w_tx_start    = 1'b0;
        w_tx_bit_end  = (r_tx_cnt == '0);
        case (r_tx_state)
            TXS_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_start    = 1'b1;
                    w_tx_state_nx = TXS_START;
                end
            end
            TXS_START: if (w_tx_bit_end) w_tx_state_nx = TXS_DATA;
            TXS_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_state_nx = TXS_STOP;
            TXS_STOP: begin
                if (w_tx_bit_end) begin
                    if (!w_tx_empty) begin
                        w_tx_pop      = 1'b1;
                        w_tx_start    = 1'b1;
                        w_tx_state_nx = TXS_START;
                    end else begin
                        w_tx_state_nx = TXS_IDLE;
                    end
                end
            end
            default: w_tx_state_nx = TXS_IDLE;
        endcase
    end

    // TX bit timer, shifter and line driver; divisor latched per frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_cnt   <= '0;
            r_tx_div   <= DIV_RESET;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txp      <= 1'b1;
        end else if (w_tx_start) begin
            r_tx_div   <= r_div;
            r_tx_cnt   <= r_div - 16'd1;
            r_tx_shift <= w_tx_rdata;
            r_tx_bit   <= '0;
            r_txp      <= 1'b0;
        end else if (r_tx_state != TXS_IDLE) begin
            if (w_tx_bit_end) begin
                r_tx_cnt <= r_tx_div - 16'd1;
                if (r_tx_state == TXS_START) begin
                    r_txp      <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                end else if (r_tx_state == TXS_DATA) begin
                    if (r_tx_bit == 3'd7) begin
                        r_txp <= 1'b1;
                    end else begin
                        r_txp      <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= r_tx_bit + 3'd1;
                    end
                end
            end else begin
                r_tx_cnt <= r_tx_cnt - 16'd1;
            end
        end
    end

    // ---------------- receiver ----------------
    assign w_rx_push = w_rx_stop_end & r_rx_s2 & ~w_rx_full;
    assign w_ov_set  = w_rx_stop_end & r_rx_s2 & w_rx_full;
    assign w_fe_set  = w_rx_stop_end & ~r_rx_s2;

    // Input synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rxp;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= RXS_IDLE;
        else       r_rx_state <= w_rx_state_nx;
    end

    // RX next-state; a start bit that is high again at mid-bit is a glitch
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_start    = 1'b0;
        w_rx_stop_end = 1'b0;
        w_rx_bit_end  = (r_rx_cnt == '0);
        case (r_rx_state)
            RXS_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_start    = 1'b1;
                    w_rx_state_nx = RXS_START;
                end
            end
            RXS_START: if (w_rx_bit_end) w_rx_state_nx = r_rx_s2 ? RXS_IDLE : RXS_DATA;
            RXS_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_state_nx = RXS_STOP;
            RXS_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_stop_end = 1'b1;
                    w_rx_state_nx = RXS_IDLE;
                end
            end
            default: w_rx_state_nx = RXS_IDLE;
        endcase
    end

    // RX bit timer and shifter; first wait is half a bit to land mid-bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= DIV_RESET;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else if (w_rx_start) begin
            r_rx_div <= r_div;
            r_rx_cnt <= (r_div >> 1) - 16'd1;
            r_rx_bit <= '0;
        end else if (r_rx_state != RXS_IDLE) begin
            if (w_rx_bit_end) begin
                r_rx_cnt <= r_rx_div - 16'd1;
                if (r_rx_state == RXS_DATA) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 3'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign done     = r_done;
    assign uart_txp = r_txp;
    assign irq      = r_irq;

endmodule

// File: tb/tb_h80cpu_uart_io.sv
// Directed/randomised bench for h80cpu_uart_io with a serial-line reference
// model (frame decoder on TX, byte queue with overrun/frame flags on RX).
module tb_h80cpu_uart_io;
    import h80cpu_uart_io_pkg::*;

    logic      clk;
    logic      reset;
    bus_addr_t addr;
    bus_cmd_t  cmd;
    logic      run;
    bus_data_t wr_data;
    bus_data_t rd_data;
    logic      done;
    logic      uart_rxp;
    logic      uart_txp;
    logic      irq;

    int n_checks = 0;
    int n_pass   = 0;

    int         mdl_div = 10;
    bit         mon_en  = 1'b1;
    logic [7:0] tx_exp[$];
    logic [7:0] tx_seen[$];
    int         tx_low[$];
    logic [7:0] rx_mdl[$];
    bit         ov_mdl = 1'b0;
    bit         fe_mdl = 1'b0;

    h80cpu_uart_io #(
        .CLK_FREQ(1000), .BAUD(100), .TX_DEPTH(16), .RX_DEPTH(16), .BASE_ADDR(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .cmd(cmd), .run(run),
        .wr_data(wr_data), .rd_data(rd_data), .done(done),
        .uart_rxp(uart_rxp), .uart_txp(uart_txp), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bus transaction; returns read data and number of edges until done toggled
    task automatic bus(input bus_cmd_t c, input bus_addr_t a, input bus_data_t d,
                       output bus_data_t q, output int lat);
        int n;
        @(negedge clk);
        cmd = c; addr = a; wr_data = d; run = ~run;
        n = 0; lat = -1;
        while (n < 4000) begin
            @(posedge clk); #1; n++;
            if (done === run) begin lat = n; break; end
        end
        if (lat < 0) check("bus_timeout", 32'(done), 32'(run));
        q = rd_data;
    endtask

    task automatic wr(input bus_addr_t a, input bus_data_t d, output int lat);
        bus_data_t q;
        bus(bus_cmd_write_b, a, d, q, lat);
    endtask

    task automatic rd(input bus_addr_t a, output bus_data_t q);
        int lat;
        bus(bus_cmd_read_b, a, 16'h0, q, lat);
    endtask

    function automatic logic [15:0] status_exp();
        logic [15:0] s;
        s = 16'h0022;                      // TX side idle and empty
        if (rx_mdl.size() > 0) s |= 16'h0004;
        if (ov_mdl)            s |= 16'h0008;
        if (fe_mdl)            s |= 16'h0010;
        return s;
    endfunction

    task automatic check_status(input string tag);
        bus_data_t q;
        rd(UART_REG_STATUS, q);
        check(tag, 32'(q), 32'(status_exp()));
        ov_mdl = 1'b0;
        fe_mdl = 1'b0;
    endtask

    task automatic check_rx_read(input string tag);
        bus_data_t q;
        logic [7:0] e;
        e = (rx_mdl.size() > 0) ? rx_mdl.pop_front() : 8'h00;
        rd(UART_REG_DATA, q);
        check(tag, 32'(q), 32'(e));
    endtask

    // Drive one serial frame at the model divisor and update the RX model
    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        logic [9:0] f;
        f = {stop_b, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); uart_rxp = f[i];
            repeat (mdl_div - 1) @(negedge clk);
        end
        @(negedge clk); uart_rxp = 1'b1;
        repeat (19) @(negedge clk);
        if (!stop_b)                fe_mdl = 1'b1;
        else if (rx_mdl.size() < 16) rx_mdl.push_back(b);
        else                        ov_mdl = 1'b1;
    endtask

    task automatic wait_tx(input int n);
        int c;
        c = 0;
        while (tx_seen.size() < n && c < 5000) begin @(posedge clk); c++; end
        check("tx_frame_count", 32'(tx_seen.size()), 32'(n));
    endtask

    // Serial decoder: mid-bit sampling at the divisor in force at the start bit
    initial begin : tx_monitor
        int d, low, t;
        bit low_run;
        logic [7:0] b;
        logic stop_v;
        forever begin
            @(posedge clk); #1;
            if (mon_en && uart_txp === 1'b0) begin
                d = mdl_div; low = 0; low_run = 1'b1; b = '0; stop_v = 1'b0;
                for (t = 0; t <= 9 * d + d / 2; t++) begin
                    if (t > 0) begin @(posedge clk); #1; end
                    if (low_run) begin
                        if (uart_txp === 1'b0) low++;
                        else low_run = 1'b0;
                    end
                    for (int k = 0; k < 8; k++)
                        if (t == d * (k + 1) + d / 2) b[k] = uart_txp;
                    if (t == 9 * d + d / 2) stop_v = uart_txp;
                end
                if (mon_en) begin
                    tx_seen.push_back(b);
                    tx_low.push_back(low);
                    check("tx_stop_bit", 32'(stop_v), 32'd1);
                end
            end
        end
    end

    initial begin : main
        bus_data_t  q;
        int         lat, bad;
        logic [7:0] b;
        logic [9:0] frame;

        reset = 1'b1; run = 1'b0; addr = '0; cmd = bus_cmd_read_b;
        wr_data = '0; uart_rxp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_txp", 32'(uart_txp), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk); reset = 1'b0;

        rd(UART_REG_DIV, q);  check("rst_div", 32'(q), 32'd10);
        rd(UART_REG_CTRL, q); check("rst_ctrl", 32'(q), 32'd0);
        check_status("rst_status");

        // 1: single 'h55 frame, full waveform against the frame bit pattern
        wr(UART_REG_DATA, 16'h0055, lat);
        check("t1_write_latency", 32'(lat), 32'd1);
        tx_exp.push_back(8'h55);
        frame = {1'b1, 8'h55, 1'b0};
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (uart_txp !== frame[t / 10]) bad++;
        end
        check("t1_waveform_errors", 32'(bad), 32'd0);
        repeat (3) @(posedge clk);
        check_status("t1_status_idle");

        // 2: 18 back-to-back writes; first pops at once, so the 18th meets a full FIFO
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom);
            wr(UART_REG_DATA, bus_data_t'(b), lat);
            tx_exp.push_back(b);
            if (i < 17 && lat != 1) bad++;
            if (i == 17) begin
                check("t2_stall_seen", 32'(lat > 1), 32'd1);
                check("t2_stall_bounded", 32'(lat < 150), 32'd1);
            end
        end
        check("t2_nonstall_latency", 32'(bad), 32'd0);
        wait_tx(19);
        repeat (10) @(posedge clk);

        // 3: receive 'hA3 with rx irq enabled, then the tx-empty irq source
        wr(UART_REG_CTRL, 16'h0001, lat);
        send_frame(8'hA3, 1'b1);
        check_status("t3_status_valid");
        check("t3_irq_set", 32'(irq), 32'd1);
        check_rx_read("t3_rx_data");
        @(posedge clk); #1;
        check("t3_irq_drop", 32'(irq), 32'd0);
        check_status("t3_status_empty");
        wr(UART_REG_CTRL, 16'h0002, lat);
        @(posedge clk); #1;
        check("t3_irq_tx_empty", 32'(irq), 32'd1);
        wr(UART_REG_CTRL, 16'h0001, lat);

        // 4: overrun with 17 frames, then framing error
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b1);
        check_status("t4_status_overrun");
        for (int i = 0; i < 16; i++) check_rx_read("t4_rx_data");
        check_rx_read("t4_rx_empty_read");
        check_status("t4_status_cleared");
        send_frame(8'($urandom), 1'b0);
        check_status("t4_status_frame_err");
        check_status("t4_status_fe_cleared");

        // 5: divisor change mid-frame affects only the following frame
        tx_low.delete();
        b = 8'($urandom) | 8'h01;
        wr(UART_REG_DATA, bus_data_t'(b), lat); tx_exp.push_back(b);
        b = 8'($urandom) | 8'h01;
        wr(UART_REG_DATA, bus_data_t'(b), lat); tx_exp.push_back(b);
        repeat (30) @(posedge clk);
        wr(UART_REG_DIV, 16'd4, lat);
        mdl_div = 4;
        wait_tx(tx_exp.size());
        check("t5_old_div_bit", 32'(tx_low[0]), 32'd10);
        check("t5_new_div_bit", 32'(tx_low[1]), 32'd4);
        repeat (10) @(posedge clk);
        wr(UART_REG_DIV, 16'd0, lat);
        mdl_div = 2;
        rd(UART_REG_DIV, q); check("t5_div0_clamp", 32'(q), 32'd2);
        wr(UART_REG_DIV, 16'd10, lat);
        mdl_div = 10;

        bad = 0;
        for (int i = 0; i < tx_exp.size() && i < tx_seen.size(); i++)
            if (tx_seen[i] !== tx_exp[i]) bad++;
        check("tx_byte_errors", 32'(bad), 32'd0);
        check("tx_byte_total", 32'(tx_seen.size()), 32'(tx_exp.size()));

        // 6: reset in the middle of a frame with three bytes still queued
        mon_en = 1'b0;
        for (int i = 0; i < 4; i++) wr(UART_REG_DATA, bus_data_t'(8'($urandom) & 8'hF0), lat);
        repeat (30) @(negedge clk);
        check("t6_txp_low_before_reset", 32'(uart_txp), 32'd0);
        reset = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        check("t6_txp_after_reset", 32'(uart_txp), 32'd1);
        check("t6_done_after_reset", 32'(done), 32'd0);
        @(negedge clk); reset = 1'b0;
        rx_mdl.delete(); ov_mdl = 1'b0; fe_mdl = 1'b0;
        check_status("t6_status");
        rd(16'h0007, q); check("t6_unmapped_read", 32'(q), 32'd0);
        rd(UART_REG_DIV, q); check("t6_div_reset", 32'(q), 32'd10);
        check("t6_irq", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
